updown_sweep_ctrl: RTL
======================

# updown_sweep_ctrl

- Sequencer for the synchronous up/down counter datapath: generates a bounded triangle sweep lo→hi→lo, repeated for a programmed number of periods.
- Owns the count register and the direction signal.
- Exposes a start/abort/done handshake so a host FSM or testbench can run timed sweeps without toggling `up_down` by hand.

## Interface
- `WIDTH`, 4, count and bound width.
- `clk` input 1 — single clock, rising edge.
- `reset_n` input 1 — synchronous, active-low reset.
- `start` input 1 — request a sweep; sampled only in IDLE.
- `abort` input 1 — terminate the sweep in progress.
- `lo` input WIDTH — lower bound; latched on accepted start.
- `hi` input WIDTH — upper bound; latched on accepted start.
- `cycles` input 8 — number of full periods to run; 0 = run until abort. Latched on accepted start.
- `hold` input 1 — freeze request; present only with `SWEEP_HOLD_EN`.
- `count` output WIDTH — current count value.
- `up_down` output 1 — direction: 1 = counting up, 0 = counting down.
- `busy` output 1 — high in UP and DOWN.
- `done` output 1 — one-cycle pulse, high while in DONE.
- `err` output 1 — one-cycle pulse on a rejected start.

## Operation
- **States:** IDLE, UP, DOWN, DONE. Internal 8-bit period counter `pcnt`.
- **Reset** (reset_n=0 at an edge): state IDLE, `count`=0, `up_down`=1, `busy`=0, `done`=0, `err`=0, `pcnt`=0. Reset overrides all other inputs, including mid-sweep; `done` is not pulsed.
- **IDLE**, start=1, abort=0:
  - If lo<hi: latch lo, hi and cycles; set `count`=lo, `up_down`=1, `pcnt`=0; go to UP.
  - If lo≥hi: `err`=1 for one cycle; stay in IDLE; `count` unchanged.
- **IDLE**, start=1 and abort=1 in the same cycle: abort wins, start is ignored, no `err`.
- **UP:** `count`←count+1. When count+1==hi: go to DOWN and set `up_down`=0.
- **DOWN:** `count`←count−1. When count−1==lo, the period is complete:
  - If cycles≠0 and pcnt+1==cycles: go to DONE.
  - Otherwise: `pcnt`←pcnt+1 (wraps at 255 when cycles=0), set `up_down`=1, go to UP.
- **DONE:** `done`=1; `count` holds lo; next state IDLE.
- **abort** in UP or DOWN: next state IDLE; `count` and `up_down` freeze at their current values; no `done`.
- `start` is ignored outside IDLE. abort in IDLE or DONE has no effect.
- **Arithmetic:** `count` never leaves [lo, hi], so no modular wrap can occur. lo=0 and hi=2^WIDTH−1 are legal.
- A live change of `lo`/`hi`/`cycles` during a sweep has no effect.

## Timing
- All outputs are registered.
- Accepted start at edge k: `count`=lo and `busy`=1 after edge k.
- `count`=hi after edge k+(hi−lo).
- One period lasts 2·(hi−lo) cycles.
- `done` is high during the cycle after edge k+cycles·2·(hi−lo). `busy`=0 in that cycle.
- Back-to-back sweeps: start is accepted at the earliest one cycle after DONE, in IDLE.
- abort latency: 1 edge.
- `err` latency: 1 edge after the rejected start.

## Configuration
- **`SWEEP_HOLD_EN` defined:**
  - Adds the `hold` input.
  - hold=1 in UP or DOWN freezes `count`, `up_down`, state and `pcnt`; `busy` stays 1.
  - abort overrides hold.
  - hold is ignored in IDLE and DONE.
- **Undefined:** no `hold` port; the sweep advances every cycle.

## Test plan
- **Single period:** WIDTH=4, lo=2, hi=5, cycles=1, start pulse → `count` 2,3,4,5,4,3,2 on consecutive cycles; `up_down` 1,1,1,0,0,0; `done`=1 exactly once, coincident with the final 2; `busy`=0 afterwards.
- **Multi-period:** lo=0, hi=15, cycles=3 → 90 cycles between start and `done`; `count` peaks at 15 three times, never exceeds 15 and never wraps to 0 from 15.
- **Reject:** lo=7, hi=7 start → `err` pulse one cycle later, state stays IDLE, `busy`=0. Repeat with lo=9, hi=3 → same result.
- **Abort:** cycles=0, lo=1, hi=6; assert abort when `count`=4 in DOWN → `count` frozen at 4, `up_down`=0, `busy`=0, `done` never asserted. A following start is accepted and restarts from lo.
- **Reset mid-sweep:** reset_n=0 for one edge while `count`=5 → `count`=0, `up_down`=1, all flags 0; start asserted together with reset_n=0 is ignored.
- **Hold** (with `SWEEP_HOLD_EN`): lo=2, hi=5, hold high for 3 cycles while `count`=4 in UP → `count` stays 4 for those 3 cycles and resumes 5,4,...; `done` is delayed by exactly 3 cycles.

Source files
------------

// File: rtl/updown_sweep_ctrl_if.sv
// Host-side bundle for the triangle sweep sequencer.
// The hold signal exists only when SWEEP_HOLD_EN is defined.
interface updown_sweep_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [7:0]       cycles;
`ifdef SWEEP_HOLD_EN
    logic             hold;
`endif
    logic [WIDTH-1:0] count;
    logic             up_down;
    logic             busy;
    logic             done;
    logic             err;

`ifdef SWEEP_HOLD_EN
    modport master (
        output start, abort, lo, hi, cycles, hold,
        input  count, up_down, busy, done, err
    );
    modport slave (
        input  start, abort, lo, hi, cycles, hold,
        output count, up_down, busy, done, err
    );
`else
    modport master (
        output start, abort, lo, hi, cycles,
        input  count, up_down, busy, done, err
    );
    modport slave (
        input  start, abort, lo, hi, cycles,
        output count, up_down, busy, done, err
    );
`endif
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Bounded lo->hi->lo triangle sweep sequencer with start/abort/done handshake.
// Optional freeze input enabled by defining SWEEP_HOLD_EN.
module updown_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    updown_sweep_ctrl_if.slave sw
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [7:0]       cyc_q, cyc_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic             up_q, up_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             hold_w;
    logic [WIDTH-1:0] inc_w;
    logic [WIDTH-1:0] dec_w;
    logic [7:0]       pinc_w;

`ifdef SWEEP_HOLD_EN
    assign hold_w = sw.hold;
`else
    assign hold_w = 1'b0;
`endif

    assign inc_w  = count_q + ONE;
    assign dec_w  = count_q - ONE;
    assign pinc_w = pcnt_q + 8'd1;

    // State and registered outputs; reset forces an idle, upward-facing counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            cyc_q   <= '0;
            pcnt_q  <= '0;
            up_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cyc_q   <= cyc_d;
            pcnt_q  <= pcnt_d;
            up_q    <= up_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; bounds are latched at start so live changes are ignored.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        cyc_d   = cyc_q;
        pcnt_d  = pcnt_q;
        up_d    = up_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (sw.start && !sw.abort) begin
                    if (sw.lo < sw.hi) begin
                        lo_d    = sw.lo;
                        hi_d    = sw.hi;
                        cyc_d   = sw.cycles;
                        count_d = sw.lo;
                        up_d    = 1'b1;
                        pcnt_d  = '0;
                        busy_d  = 1'b1;
                        state_d = UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            UP: begin
                if (sw.abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!hold_w) begin
                    count_d = inc_w;
                    if (inc_w == hi_q) begin
                        up_d    = 1'b0;
                        state_d = DOWN;
                    end
                end
            end
            DOWN: begin
                if (sw.abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (!hold_w) begin
                    count_d = dec_w;
                    if (dec_w == lo_q) begin
                        if (cyc_q != 8'd0 && pinc_w == cyc_q) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            pcnt_d  = pinc_w;
                            up_d    = 1'b1;
                            state_d = UP;
                        end
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign sw.count   = count_q;
    assign sw.up_down = up_q;
    assign sw.busy    = busy_q;
    assign sw.done    = done_q;
    assign sw.err     = err_q;
endmodule
